// File: rtl/cache_pkg.sv
// Shared field positions and widths for the 2-way set-associative cache tag logic.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cache_pkg;

    // Geometry: 8 indices, 32 B lines, 2 ways.
    localparam int INDEX_W   = 3;
    localparam int HALT_W    = 4;
    localparam int MAIN_W    = 20;
    localparam int NUM_LINES = 8;

    // Address field boundaries.
    localparam int IDX_LSB   = 5;
    localparam int IDX_MSB   = 7;
    localparam int HALT_LSB  = 8;
    localparam int HALT_MSB  = 11;
    localparam int MAIN_LSB  = 12;

endpackage

// File: rtl/tag_eq_cmp.sv
// Gated equality comparator: out = en & (a == b); a disabled compare reads as 0.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   en  in  1  compare enable
//   a   in  W  first operand
//   b   in  W  second operand
//   out out 1  enabled equality result
module tag_eq_cmp #(
    parameter int W = 4
) (
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out
);

    assign out = en & (a == b);

endmodule

// File: rtl/cache_tag_match_fifo.sv
// Hit detection for a 2-way, 8-index cache plus a per-index FIFO victim pointer.
// Latency: hit/way_sel/victim_way combinational; victim pointer updates on the clock edge after a req miss.
// Backpressure: none; every req is accepted, a miss consumes the indexed victim immediately.
//
// Ports:
//   clk           in   1              rising-edge clock
//   reset         in   1              synchronous, active-low reset of the victim pointers
//   addr          in   32             access address
//   req           in   1              access strobe, qualifies the victim pointer update
//   halt_tags_w0  in   8*HALT_W       way-0 partial tags, line i at [4i+3:4i]
//   halt_tags_w1  in   8*HALT_W       way-1 partial tags, same packing
//   main_tag_w0   in   MAIN_W         way-0 main tag of the indexed line
//   main_tag_w1   in   MAIN_W         way-1 main tag of the indexed line
//   valid_w0      in   1              way-0 valid bit of the indexed line
//   valid_w1      in   1              way-1 valid bit of the indexed line
//   hit           out  1              either way hits
//   way_sel       out  1              data-mux select, 1 = way 1
//   victim_way    out  1              FIFO victim way for addr's index
module cache_tag_match_fifo
    import cache_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   addr,
    input  logic                          req,
    input  logic [NUM_LINES*HALT_W-1:0]   halt_tags_w0,
    input  logic [NUM_LINES*HALT_W-1:0]   halt_tags_w1,
    input  logic [MAIN_W-1:0]             main_tag_w0,
    input  logic [MAIN_W-1:0]             main_tag_w1,
    input  logic                          valid_w0,
    input  logic                          valid_w1,
    output logic                          hit,
    output logic                          way_sel,
    output logic                          victim_way
);

    logic [INDEX_W-1:0]   idx;
    logic [HALT_W-1:0]    halt_tag;
    logic [MAIN_W-1:0]    main_tag;

    logic [NUM_LINES-1:0] halt_eq_w0;
    logic [NUM_LINES-1:0] halt_eq_w1;
    logic                 eq_idx_w0;
    logic                 eq_idx_w1;
    logic                 main_eq_w0;
    logic                 main_eq_w1;
    logic                 way_hit_w0;
    logic                 way_hit_w1;

    logic [NUM_LINES-1:0] ptr;

    // Byte offset does not take part in tag matching.
    logic                 unused_offset;
    assign unused_offset = ^addr[IDX_LSB-1:0];

    assign idx      = addr[IDX_MSB:IDX_LSB];
    assign halt_tag = addr[HALT_MSB:HALT_LSB];
    assign main_tag = addr[31:MAIN_LSB];

    // The partial tag is compared against every line of both ways in parallel;
    // only the indexed line's result is then used.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_halt
        tag_eq_cmp #(.W(HALT_W)) u_halt_w0 (
            .en  (1'b1),
            .a   (halt_tag),
            .b   (halt_tags_w0[i*HALT_W +: HALT_W]),
            .out (halt_eq_w0[i])
        );
        tag_eq_cmp #(.W(HALT_W)) u_halt_w1 (
            .en  (1'b1),
            .a   (halt_tag),
            .b   (halt_tags_w1[i*HALT_W +: HALT_W]),
            .out (halt_eq_w1[i])
        );
    end

    assign eq_idx_w0 = halt_eq_w0[idx];
    assign eq_idx_w1 = halt_eq_w1[idx];

    // Main compare is only meaningful once the partial tag of the indexed line matched.
    tag_eq_cmp #(.W(MAIN_W)) u_main_w0 (
        .en  (eq_idx_w0),
        .a   (main_tag),
        .b   (main_tag_w0),
        .out (main_eq_w0)
    );
    tag_eq_cmp #(.W(MAIN_W)) u_main_w1 (
        .en  (eq_idx_w1),
        .a   (main_tag),
        .b   (main_tag_w1),
        .out (main_eq_w1)
    );

    assign way_hit_w0 = main_eq_w0 & valid_w0;
    assign way_hit_w1 = main_eq_w1 & valid_w1;
    assign hit        = way_hit_w0 | way_hit_w1;
    // Both ways hitting is illegal; way 1 is chosen so the mux select stays defined.
    assign way_sel    = hit & way_hit_w1;

    assign victim_way = ptr[idx];

    // FIFO replacement: a miss consumes the indexed victim and flips to the other way.
    // Hits never reorder. Reset wins over a simultaneous miss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (req && !hit) begin
            ptr[idx] <= ~ptr[idx];
        end
    end

endmodule

// File: tb/tb_cache_tag_match_fifo.sv
module tb_cache_tag_match_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        req;
    logic [31:0] halt_tags_w0;
    logic [31:0] halt_tags_w1;
    logic [19:0] main_tag_w0;
    logic [19:0] main_tag_w1;
    logic        valid_w0;
    logic        valid_w1;
    logic        hit;
    logic        way_sel;
    logic        victim_way;

    int checks = 0;
    int errors = 0;

    cache_tag_match_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .req          (req),
        .halt_tags_w0 (halt_tags_w0),
        .halt_tags_w1 (halt_tags_w1),
        .main_tag_w0  (main_tag_w0),
        .main_tag_w1  (main_tag_w1),
        .valid_w0     (valid_w0),
        .valid_w1     (valid_w1),
        .hit          (hit),
        .way_sel      (way_sel),
        .victim_way   (victim_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ht0;
        logic [31:0] ht1;
        logic [19:0] m0;
        logic [19:0] m1;
        logic        v0;
        logic        v1;
        logic        e_hit;
        logic        e_sel;
    } vec_t;

    vec_t tbl [9];

    // Halt tag vector with every line set to fill except one line set to val.
    function automatic logic [31:0] mk_halt(input int line, input logic [3:0] val,
                                            input logic [3:0] fill);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = fill;
        r[line*4 +: 4] = val;
        return r;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Step one rising edge and land 1 time unit after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A3 = 32'h00A00062;  // idx 3, halt 0, main 0x00A00
    localparam logic [31:0] A5 = 32'h000000A0;  // idx 5, halt 0, main 0

    initial begin
        // Directed vectors, applied with req=0 while all pointers are 0.
        tbl[0] = '{A3, mk_halt(3, 4'h0, 4'hF), mk_halt(3, 4'h5, 4'hF), 20'h00A00, 20'h00A00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{A3, mk_halt(3, 4'h5, 4'hF), mk_halt(3, 4'h0, 4'hF), 20'h00A00, 20'h00A00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{A3, mk_halt(3, 4'h0, 4'hF), mk_halt(3, 4'h0, 4'hF), 20'h00A00, 20'h00A00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{A3, mk_halt(3, 4'h0, 4'hF), mk_halt(3, 4'h5, 4'hF), 20'h00A01, 20'h00A00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{A3, mk_halt(3, 4'h0, 4'hF), mk_halt(3, 4'h5, 4'hF), 20'h00A00, 20'h00A00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{A3, mk_halt(2, 4'h0, 4'h5), mk_halt(2, 4'h0, 4'h5), 20'h00A00, 20'h00A00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{A3, mk_halt(3, 4'h0, 4'hF), mk_halt(3, 4'h0, 4'hF), 20'h00A01, 20'h00A00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFFF7E5, mk_halt(7, 4'h7, 4'h0), mk_halt(7, 4'h7, 4'h0), 20'hFFFFE, 20'hFFFFF, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{32'h12345A1F, mk_halt(0, 4'hA, 4'h0), mk_halt(0, 4'hA, 4'h0), 20'h12345, 20'h12345, 1'b1, 1'b0, 1'b1, 1'b0};

        reset        = 1'b0;
        req          = 1'b0;
        addr         = '0;
        halt_tags_w0 = '0;
        halt_tags_w1 = '0;
        main_tag_w0  = '0;
        main_tag_w1  = '0;
        valid_w0     = 1'b0;
        valid_w1     = 1'b0;

        // Reset, then all pointers read 0 and nothing hits with valids low.
        edge_step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = {24'h0, 3'(i), 5'h0};
            #1;
            chk($sformatf("reset_victim_idx%0d", i), victim_way, 1'b0);
            chk($sformatf("reset_nohit_idx%0d", i), hit, 1'b0);
        end

        // Combinational hit/way_sel table.
        for (int k = 0; k < 9; k++) begin
            addr         = tbl[k].addr;
            halt_tags_w0 = tbl[k].ht0;
            halt_tags_w1 = tbl[k].ht1;
            main_tag_w0  = tbl[k].m0;
            main_tag_w1  = tbl[k].m1;
            valid_w0     = tbl[k].v0;
            valid_w1     = tbl[k].v1;
            #1;
            chk($sformatf("vec%0d_hit", k), hit, tbl[k].e_hit);
            chk($sformatf("vec%0d_way_sel", k), way_sel, tbl[k].e_sel);
            chk($sformatf("vec%0d_victim", k), victim_way, 1'b0);
        end

        // Hit with req does not move the pointer.
        addr         = A3;
        halt_tags_w0 = mk_halt(3, 4'h0, 4'hF);
        halt_tags_w1 = mk_halt(3, 4'h5, 4'hF);
        main_tag_w0  = 20'h00A00;
        main_tag_w1  = 20'h00A00;
        valid_w0     = 1'b1;
        valid_w1     = 1'b1;
        req          = 1'b1;
        #1;
        chk("hit_req_hit", hit, 1'b1);
        edge_step();
        chk("hit_req_ptr3_hold", victim_way, 1'b0);

        // Misses at idx 3 alternate the victim.
        valid_w0 = 1'b0;
        #1;
        chk("miss_hit_low", hit, 1'b0);
        chk("miss_victim_e0", victim_way, 1'b0);
        edge_step();
        chk("miss_victim_e1", victim_way, 1'b1);
        edge_step();
        chk("miss_victim_e2", victim_way, 1'b0);
        edge_step();
        chk("miss_victim_e3", victim_way, 1'b1);
        req  = 1'b0;
        addr = 32'h00A00042;  // idx 2
        #1;
        chk("idx2_untouched", victim_way, 1'b0);

        // Miss without req leaves the pointer alone.
        addr = A3;
        edge_step();
        chk("noreq_ptr3_hold", victim_way, 1'b1);

        // Move ptr[5] to 1, then reset during a req miss at idx 5.
        addr         = A5;
        halt_tags_w0 = 32'hFFFFFFFF;
        halt_tags_w1 = 32'hFFFFFFFF;
        req          = 1'b1;
        #1;
        chk("idx5_miss", hit, 1'b0);
        edge_step();
        chk("idx5_ptr_set", victim_way, 1'b1);
        reset = 1'b0;
        // Hit stays combinational while reset is held.
        halt_tags_w0 = mk_halt(5, 4'h0, 4'hF);
        main_tag_w0  = 20'h00000;
        valid_w0     = 1'b1;
        #1;
        chk("hit_during_reset", hit, 1'b1);
        valid_w0 = 1'b0;
        edge_step();
        reset = 1'b1;
        req   = 1'b0;
        #1;
        chk("reset_wins_idx5", victim_way, 1'b0);
        addr = A3;
        #1;
        chk("reset_clears_idx3", victim_way, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
